// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Takes 34 cycles from an accepted Start to the Done pulse, whatever the
// operation or operand values, so the controller's stall window never varies.
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   Start       - request pulse, accepted only in IDLE
//   funct3      - M-op select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   SrcA, SrcB  - rs1 / rs2 operands, captured when Start is accepted
//   Busy        - high from the cycle after acceptance through the Done cycle
//   Done        - one-cycle pulse; Result is valid in that cycle
//   Result      - registered result, held until the next result is written
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;        // |A|: multiplicand, or dividend shifted out MSB-first
  logic [WIDTH-1:0] b_q, b_d;        // |B|: multiplier shifted out LSB-first, or divisor
  logic [WIDTH-1:0] srca_q, srca_d;  // raw SrcA, returned by REM/REMU on divide-by-zero
  logic [PW-1:0]    acc_q, acc_d;    // mul: product; div: {remainder, quotient}
  logic             neg_q, neg_d;    // the result magnitude must be negated in FIX
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             is_div;
  logic             signed_a, signed_b, sign_a, sign_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_qbit;
  logic [WIDTH-1:0] div_rem;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] quot_mag, rem_mag;

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      srca_q   <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      srca_q   <= srca_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = S_CALC;
      S_CALC:  if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output logic
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    srca_d   = srca_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    is_div   = op_q[2];
    signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    signed_b = signed_a && (funct3 != 3'b010);
    sign_a   = signed_a && SrcA[WIDTH-1];
    sign_b   = signed_b && SrcB[WIDTH-1];

    // One shift-add step: add |A| into the high half when the multiplier LSB is set
    mul_sum   = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};
    // One restoring step: bring down the next dividend bit and trial-subtract
    div_shift = {acc_q[PW-1:WIDTH], a_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_qbit  = (div_shift >= {1'b0, b_q});
    div_rem   = div_qbit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];

    prod     = neg_q ? (PW'(0) - acc_q) : acc_q;
    quot_mag = acc_q[WIDTH-1:0];
    rem_mag  = acc_q[PW-1:WIDTH];

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          op_d   = funct3;
          a_d    = sign_a ? (WIDTH'(0) - SrcA) : SrcA;
          b_d    = sign_b ? (WIDTH'(0) - SrcB) : SrcB;
          srca_d = SrcA;
          // Remainders take the dividend's sign; everything else the product of signs
          neg_d  = funct3[2] && funct3[1] ? sign_a : (sign_a ^ sign_b);
          acc_d  = '0;
          cnt_d  = '0;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (is_div) begin
          acc_d = {div_rem, acc_q[WIDTH-2:0], div_qbit};
          a_d   = {a_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          b_d   = {1'b0, b_q[WIDTH-1:1]};
        end
      end
      S_FIX: begin
        if (!is_div) begin
          result_d = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[PW-1:WIDTH];
        end else if (b_q == '0) begin
          result_d = op_q[1] ? srca_q : '1;
        end else if (op_q[1]) begin
          result_d = neg_q ? (WIDTH'(0) - rem_mag) : rem_mag;
        end else begin
          // Signed overflow needs no special path: |MIN|/1 gives MIN, remainder 0
          result_d = neg_q ? (WIDTH'(0) - quot_mag) : quot_mag;
        end
      end
      default: ;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit that consumes the decoded M-extension operation (funct3) and register operands and returns a 32-bit result after a fixed number of cycles. It sits beside the single-cycle ALU in the datapath. The controller stalls the PC and register write-back while Busy is high, and commits Result on Done.

## Interface

Parameters:
- WIDTH, 32, operand and result width. Only 32 is supported for RV32M; the iteration counter is sized as clog2(WIDTH)+1.

Ports (one clock, synchronous active-high reset):
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; returns the unit to IDLE
- Start  input  1  request pulse; sampled only in IDLE
- funct3  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  input  WIDTH  rs1 value; dividend / multiplicand
- SrcB  input  WIDTH  rs2 value; divisor / multiplier
- Busy  output  1  high from the cycle after Start is accepted until Done
- Done  output  1  one-cycle pulse; Result valid
- Result  output  WIDTH  registered result; held until the next accepted Start

## Operation

- States:
  - IDLE: wait for Start.
  - CALC: WIDTH iterations.
  - FIX: sign correction and selection of the special cases.
  - DONE: Done=1 for one cycle, then IDLE.
- IDLE & Start: latch funct3, latch the absolute values of the operands, and latch the result sign flags. Clear the counter and the accumulator. Go to CALC.
- Signedness of the operands:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: SrcA signed, SrcB unsigned.
  - All other ops: both operands unsigned.
- Multiply: shift-add over 2*WIDTH-bit magnitude product, one multiplier bit per cycle.
  - FIX negates the product if the result sign is 1.
  - MUL returns product[WIDTH-1:0].
  - MULH, MULHSU and MULHU return product[2*WIDTH-1:WIDTH].
- Divide: restoring division on magnitudes, one quotient bit per cycle.
  - Quotient sign = signA XOR signB.
  - Remainder sign = signA.
- Divisor == 0 (checked on the latched SrcB):
  - DIV and DIVU return 0xFFFFFFFF.
  - REM and REMU return the original SrcA.
- Signed overflow (DIV with SrcA=0x80000000 and SrcB=0xFFFFFFFF):
  - DIV returns 0x80000000.
  - REM returns 0.
- The special cases do not shorten latency. Every op takes the same number of cycles.
- Start while not in IDLE is ignored. Operands and funct3 may change freely after acceptance.
- The DONE state is left unconditionally. A Start presented during DONE is ignored. A Start in the following IDLE cycle is accepted.

## Timing

- Reset values: state=IDLE, Busy=0, Done=0, Result=0, counter=0.
- Edge E0: Start is sampled in IDLE.
- Edges E1..E32: CALC iterations.
- Edge E33: FIX writes Result.
- Edge E34: DONE ends.
- Busy is high during the cycles after E0 through the cycle after E33, inclusive.
- Done is high only in the cycle after E33. Result is valid in that cycle.
- Start-to-Done latency: 34 cycles, counting the Start cycle as cycle 0 and Done in cycle 34. Back-to-back throughput is one op per 35 cycles.
- Reset has priority over all state. Reset asserted mid-CALC:
  - The next cycle shows IDLE, Busy=0, Done=0 and Result=0.
  - The in-flight operation is discarded with no Done pulse.
- Start and reset in the same cycle: reset wins and Start is not accepted.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan

- Reset, then MUL with SrcA=7, SrcB=6 -> Busy rises the next cycle; Done pulses exactly 34 cycles after Start with Result=42; Busy low after Done.
- MULH with 0x80000000 × 0x80000000 -> Result=0x40000000. MULHSU with 0xFFFFFFFF × 0xFFFFFFFF -> Result=0xFFFFFFFF. MULHU with the same operands -> Result=0xFFFFFFFE.
- DIV with -7 / 2 -> 0xFFFFFFFD (-3). REM with -7 / 2 -> 0xFFFFFFFF (-1). DIVU with 0xFFFFFFFF / 2 -> 0x7FFFFFFF. REMU with 7 / 0xFFFFFFFF -> 7.
- Special cases:
  - DIV with 5/0 -> 0xFFFFFFFF; REMU with 5/0 -> 5.
  - DIV with 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
  - All four complete in exactly 34 cycles.
- Start pulsed again at cycles 5 and 34 of an operation, with different operands -> both are ignored and the first Result is unchanged. Start at cycle 35 is accepted and its Done arrives at cycle 69.
- Reset asserted at cycle 10 of a DIVU -> Busy=0, Done=0 and Result=0 the next cycle, with no Done pulse. A new MUL 3×3 afterwards returns 9 with normal latency.
